// File: rtl/mips_bus_arbiter.sv
// Two-port round-robin arbiter sharing one Avalon-style memory bus between
// the instruction-fetch port and the load/store port of the MIPS bus CPU.
`timescale 1ns/1ps

module mips_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  // instruction port
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  // data port
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  // shared memory bus
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  // sticky stall-timeout flag
  output logic        bus_timeout
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned BEW   = 4;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] BUS_I  = 3'd1;
  localparam logic [2:0] BUS_D  = 3'd2;
  localparam logic [2:0] DONE_I = 3'd3;
  localparam logic [2:0] DONE_D = 3'd4;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [2:0]       state_q,      state_d;
  logic             last_grant_q, last_grant_d;
  logic [AW-1:0]    address_q,    address_d;
  logic             read_q,       read_d;
  logic             write_q,      write_d;
  logic [DW-1:0]    writedata_q,  writedata_d;
  logic [BEW-1:0]   byteenable_q, byteenable_d;
  logic [DW-1:0]    i_rdata_q,    i_rdata_d;
  logic [DW-1:0]    d_rdata_q,    d_rdata_d;
  logic             i_wait_q,     i_wait_d;
  logic             d_wait_q,     d_wait_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             timeout_q,    timeout_d;

  logic i_pend;
  logic d_pend;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_wait_q     <= 1'b1;
      d_wait_q     <= 1'b1;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_wait_q     <= i_wait_d;
      d_wait_q     <= d_wait_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state: grant, bus hold, completion and stall watchdog
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;

    case (state_q)
      IDLE: begin
        if (i_pend && (!d_pend || (last_grant_q == GRANT_D))) begin
          state_d      = BUS_I;
          last_grant_d = GRANT_I;
          address_d    = i_address;
          read_d       = 1'b1;
          write_d      = 1'b0;
          writedata_d  = '0;
          byteenable_d = {BEW{1'b1}};
          cnt_d        = '0;
        end else if (d_pend) begin
          state_d      = BUS_D;
          last_grant_d = GRANT_D;
          address_d    = d_address;
          write_d      = d_write;
          read_d       = d_read & ~d_write;
          writedata_d  = d_writedata;
          byteenable_d = d_byteenable;
          cnt_d        = '0;
        end
      end
      BUS_I, BUS_D: begin
        if (!waitrequest) begin
          if (state_q == BUS_I) begin
            i_rdata_d = readdata;
            state_d   = DONE_I;
          end else begin
            if (read_q) d_rdata_d = readdata;
            state_d = DONE_D;
          end
          read_d  = 1'b0;
          write_d = 1'b0;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_MAX) timeout_d = 1'b1;
        end
      end
      DONE_I, DONE_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase

    i_wait_d = (state_d != DONE_I);
    d_wait_d = (state_d != DONE_D);
  end

  assign address       = address_q;
  assign read          = read_q;
  assign write         = write_q;
  assign writedata     = writedata_q;
  assign byteenable    = byteenable_q;
  assign i_readdata    = i_rdata_q;
  assign d_readdata    = d_rdata_q;
  assign i_waitrequest = i_wait_q;
  assign d_waitrequest = d_wait_q;
  assign bus_timeout   = timeout_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: directed port transactions push
// expected bus/response records; a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_mips_bus_arbiter;

  typedef struct packed {
    logic [31:0] a;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  be;
  } bus_t;

  typedef struct packed {
    logic        port;   // 0 = I, 1 = D
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        bus_timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_cfg = 0;
  int stall_cnt = 0;
  int bus_cycles = 0;
  bit prev_strobe = 1'b0;
  bus_t bus_snap;

  bus_t  bus_q[$];
  resp_t resp_q[$];

  mips_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read),
    .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata),
    .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: stalls stall_cfg cycles per transaction
  always @(posedge clk) begin
    if (read || write) begin
      if (stall_cnt < stall_cfg) stall_cnt <= stall_cnt + 1;
    end else begin
      stall_cnt <= 0;
    end
  end

  assign waitrequest = (stall_cnt < stall_cfg);

  always_comb begin
    if (address == 32'hBFC0_0000) readdata = 32'h2402_0005;
    else                          readdata = address ^ 32'h5A5A_0000;
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bus_t cur_bus();
    bus_t b;
    b.a  = address;
    b.rd = read;
    b.wr = write;
    b.wd = writedata;
    b.be = byteenable;
    return b;
  endfunction

  function automatic bus_t mk_bus(input logic [31:0] a, input logic rd, input logic wr,
                                  input logic [31:0] wd, input logic [3:0] be);
    bus_t b;
    b.a = a; b.rd = rd; b.wr = wr; b.wd = wd; b.be = be;
    return b;
  endfunction

  function automatic resp_t mk_resp(input logic port, input logic [31:0] data);
    resp_t r;
    r.port = port;
    r.data = data;
    return r;
  endfunction

  // Monitor: pop expected records when the DUT presents bus starts or responses
  always @(negedge clk) begin
    resp_t r;
    bus_t  b;
    bit    strobe;
    if (!i_waitrequest) begin
      if (resp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected_i actual=%h required=none", i_readdata);
      end else begin
        r = resp_q.pop_front();
        chk("resp_port_i", 96'(1'b0), 96'(r.port));
        chk("resp_data_i", 96'(i_readdata), 96'(r.data));
      end
    end
    if (!d_waitrequest) begin
      if (resp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected_d actual=%h required=none", d_readdata);
      end else begin
        r = resp_q.pop_front();
        chk("resp_port_d", 96'(1'b1), 96'(r.port));
        chk("resp_data_d", 96'(d_readdata), 96'(r.data));
      end
    end
    strobe = read | write;
    if (strobe && !prev_strobe) begin
      bus_snap = cur_bus();
      bus_cycles = 1;
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_unexpected actual=%h required=none", bus_snap);
      end else begin
        b = bus_q.pop_front();
        chk("bus_fields", 96'(bus_snap), 96'(b));
      end
    end else if (strobe) begin
      bus_cycles++;
      chk("bus_stable", 96'(cur_bus()), 96'(bus_snap));
    end
    prev_strobe = strobe;
  end

  // Wait (bounded) for a port's waitrequest to drop; returns cycles since c0
  task automatic wait_done(input bit port, input int c0, input string name, output int lat);
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if ((port == 1'b0 && !i_waitrequest) || (port == 1'b1 && !d_waitrequest)) seen = 1'b1;
    end
    lat = cyc - c0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_response required=response", name);
      lat = -1;
    end
  endtask

  task automatic issue_i(input logic [31:0] a, input int stalls, output int lat);
    int c0;
    @(posedge clk); #1;
    stall_cfg = stalls;
    i_address = a;
    i_read = 1'b1;
    c0 = cyc;
    wait_done(1'b0, c0, "issue_i", lat);
    @(posedge clk); #1;
    i_read = 1'b0;
  endtask

  initial begin
    int lat;
    int c0;
    int nresp;
    reset = 1'b1;
    i_address = '0; i_read = 1'b0;
    d_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_writedata = '0; d_byteenable = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_bus", 96'(cur_bus()), 96'(mk_bus(32'h0, 1'b0, 1'b0, 32'h0, 4'h0)));
    chk("rst_i_wait", 96'(i_waitrequest), 96'(1'b1));
    chk("rst_d_wait", 96'(d_waitrequest), 96'(1'b1));
    chk("rst_i_rdata", 96'(i_readdata), 96'(32'h0));
    chk("rst_d_rdata", 96'(d_readdata), 96'(32'h0));
    chk("rst_timeout", 96'(bus_timeout), 96'(1'b0));

    // Contention right after reset: I, D, I, D
    @(posedge clk); #1;
    reset = 1'b0;
    stall_cfg = 0;
    i_address = 32'h0000_0100;
    d_address = 32'h0000_0200;
    d_writedata = 32'h1111_2222;
    d_byteenable = 4'hC;
    for (int k = 0; k < 2; k++) begin
      bus_q.push_back(mk_bus(32'h0000_0100, 1'b1, 1'b0, 32'h0, 4'hF));
      resp_q.push_back(mk_resp(1'b0, 32'h5A5A_0100));
      bus_q.push_back(mk_bus(32'h0000_0200, 1'b1, 1'b0, 32'h1111_2222, 4'hC));
      resp_q.push_back(mk_resp(1'b1, 32'h5A5A_0200));
    end
    i_read = 1'b1;
    d_read = 1'b1;
    nresp = 0;
    for (int k = 0; k < 100 && nresp < 4; k++) begin
      @(negedge clk);
      if (!i_waitrequest || !d_waitrequest) nresp++;
    end
    chk("contention_count", 96'(nresp), 96'(4));
    @(posedge clk); #1;
    i_read = 1'b0;
    d_read = 1'b0;

    // Single instruction fetch, zero stall: 2-cycle response
    bus_q.push_back(mk_bus(32'hBFC0_0000, 1'b1, 1'b0, 32'h0, 4'hF));
    resp_q.push_back(mk_resp(1'b0, 32'h2402_0005));
    issue_i(32'hBFC0_0000, 0, lat);
    chk("fetch_latency", 96'(lat), 96'(2));

    // Data write with 5 stall cycles
    bus_q.push_back(mk_bus(32'h0000_0010, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0011));
    resp_q.push_back(mk_resp(1'b1, 32'h5A5A_0200));
    @(posedge clk); #1;
    stall_cfg = 5;
    d_address = 32'h0000_0010;
    d_writedata = 32'hDEAD_BEEF;
    d_byteenable = 4'b0011;
    d_write = 1'b1;
    c0 = cyc;
    wait_done(1'b1, c0, "write_stall", lat);
    chk("write_latency", 96'(lat), 96'(7));
    chk("write_bus_cycles", 96'(bus_cycles), 96'(6));
    @(posedge clk); #1;
    d_write = 1'b0;
    @(negedge clk);
    chk("write_done_one_cycle", 96'(d_waitrequest), 96'(1'b1));

    // Read+write together on D: write wins
    bus_q.push_back(mk_bus(32'h0000_0020, 1'b0, 1'b1, 32'hCAFE_F00D, 4'hF));
    resp_q.push_back(mk_resp(1'b1, 32'h5A5A_0200));
    @(posedge clk); #1;
    stall_cfg = 1;
    d_address = 32'h0000_0020;
    d_writedata = 32'hCAFE_F00D;
    d_byteenable = 4'hF;
    d_read = 1'b1;
    d_write = 1'b1;
    c0 = cyc;
    wait_done(1'b1, c0, "rw_d", lat);
    chk("rw_latency", 96'(lat), 96'(3));
    @(posedge clk); #1;
    d_read = 1'b0;
    d_write = 1'b0;

    // Timeout: 20 stall cycles, flag rises at the edge closing stall cycle 8
    bus_q.push_back(mk_bus(32'h0000_0300, 1'b1, 1'b0, 32'h0, 4'hF));
    resp_q.push_back(mk_resp(1'b0, 32'h5A5A_0300));
    @(posedge clk); #1;
    stall_cfg = 20;
    i_address = 32'h0000_0300;
    i_read = 1'b1;
    c0 = cyc;
    @(negedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) chk("to_strobe", 96'(read), 96'(1'b1));
      if (k == 8) chk("to_before", 96'(bus_timeout), 96'(1'b0));
      if (k == 9) chk("to_rise", 96'(bus_timeout), 96'(1'b1));
    end
    wait_done(1'b0, c0, "timeout_txn", lat);
    chk("to_latency", 96'(lat), 96'(22));
    @(posedge clk); #1;
    i_read = 1'b0;
    repeat (2) @(negedge clk);
    chk("to_sticky", 96'(bus_timeout), 96'(1'b1));

    // Async reset while in BUS_D
    bus_q.push_back(mk_bus(32'h0000_0040, 1'b0, 1'b1, 32'h0BAD_F00D, 4'hF));
    @(posedge clk); #1;
    stall_cfg = 10;
    d_address = 32'h0000_0040;
    d_writedata = 32'h0BAD_F00D;
    d_byteenable = 4'hF;
    d_write = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_in_bus", 96'(write), 96'(1'b1));
    reset = 1'b1;
    #1;
    chk("ar_strobes", 96'({read, write}), 96'(2'b00));
    chk("ar_d_wait", 96'(d_waitrequest), 96'(1'b1));
    chk("ar_timeout_clr", 96'(bus_timeout), 96'(1'b0));
    chk("ar_d_rdata", 96'(d_readdata), 96'(32'h0));
    d_write = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Normal fetch after reset release
    bus_q.push_back(mk_bus(32'h0000_0400, 1'b1, 1'b0, 32'h0, 4'hF));
    resp_q.push_back(mk_resp(1'b0, 32'h5A5A_0400));
    issue_i(32'h0000_0400, 2, lat);
    chk("post_reset_latency", 96'(lat), 96'(4));

    repeat (3) @(negedge clk);
    chk("bus_q_empty", 96'(bus_q.size()), 96'(0));
    chk("resp_q_empty", 96'(resp_q.size()), 96'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-port arbiter that shares the single Avalon-style memory bus of the MIPS bus CPU between the instruction-fetch unit and the load/store unit. Each port issues one transaction at a time. The arbiter picks a port (round-robin on contention) and latches that port's request. It drives the latched request onto the shared bus until the memory releases `waitrequest`, then returns the read data to the granted port through a registered response cycle. It sits between the CPU's internal fetch/memory stages and the external bus ports of `mips_cpu_bus`.

## Interface
- `TIMEOUT_CYCLES`, default 1024: a bus transaction stalled longer than this many cycles sets the sticky `bus_timeout` flag.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; returns the FSM to IDLE immediately.
- `i_address` in 32: instruction-port byte address (word aligned).
- `i_read` in 1: instruction-port read request, held until `i_waitrequest` is low.
- `i_waitrequest` out 1: instruction-port stall.
- `i_readdata` out 32: instruction-port read data; valid while `i_waitrequest` is 0.
- `d_address` in 32: data-port byte address.
- `d_read` in 1: data-port read request.
- `d_write` in 1: data-port write request.
- `d_writedata` in 32: data-port write data.
- `d_byteenable` in 4: data-port byte lanes.
- `d_waitrequest` out 1: data-port stall.
- `d_readdata` out 32: data-port read data; valid while `d_waitrequest` is 0.
- `address` out 32: shared bus address.
- `read` out 1: shared bus read strobe.
- `write` out 1: shared bus write strobe.
- `writedata` out 32: shared bus write data.
- `byteenable` out 4: shared bus byte lanes.
- `waitrequest` in 1: memory stall.
- `readdata` in 32: memory read data; valid in the cycle `waitrequest` is 0.
- `bus_timeout` out 1: sticky stall-timeout flag; cleared only by reset.

## Operation
- FSM states: IDLE, BUS_I, BUS_D, DONE_I, DONE_D.
- **IDLE**, request pending:
  - `i_pend = i_read`; `d_pend = d_read | d_write`.
  - Only one port pending: that port is granted.
  - Both pending: the port not recorded in `last_grant` is granted.
  - `last_grant` resets to D, so the instruction port wins the first contention after reset.
- **Grant edge**: the granted port's request is latched into the bus output registers and `last_grant` is updated.
  - I grant: `address=i_address`, `read=1`, `write=0`, `writedata=0`, `byteenable=4'hF`. Next state BUS_I.
  - D grant: `address=d_address`, `writedata=d_writedata`, `byteenable=d_byteenable`. Next state BUS_D.
  - D grant with `d_write=1`: `write=1`, `read=0`, even if `d_read` is also 1 (write wins).
  - D grant with only `d_read=1`: `read=1`, `write=0`.
- **BUS_x**: the latched outputs are held stable.
  - On a rising edge with `waitrequest=0`: `readdata` is captured into the port's response register (reads only; writes leave it unchanged), `read`/`write` clear to 0, and the FSM moves to DONE_x.
- **DONE_x**: the corresponding port `x_waitrequest=0` for exactly one cycle; the next state is IDLE.
- Port waitrequest outputs are 1 in every state except the port's own DONE state.
- A requester deasserting its request mid-transaction does not abort it. The bus transaction and DONE cycle still complete; the requester ignores the DONE cycle.
- **Timeout counter**: clears on entry to BUS_x and increments each BUS_x cycle with `waitrequest=1`, saturating at `TIMEOUT_CYCLES`. Reaching `TIMEOUT_CYCLES` sets `bus_timeout`. The transaction is not aborted.

## Timing
- **Reset values** (applied asynchronously):
  - State IDLE, `last_grant` = D.
  - `address=0`, `read=0`, `write=0`, `writedata=0`, `byteenable=0`.
  - `i_waitrequest=1`, `d_waitrequest=1`, `i_readdata=0`, `d_readdata=0`.
  - `bus_timeout=0`, timeout counter 0.
- **Latency**: request seen in IDLE in cycle 0, bus strobe visible in cycle 1.
  - With `waitrequest=0` in cycle 1, the port sees waitrequest low in cycle 2.
  - Minimum 3 cycles per transaction; each stall cycle adds 1.
- **Bus outputs** are registered only; there is no combinational path from port inputs to bus outputs.
- **Port `readdata`** is registered and holds its last value until the next read completion for that port.
- **Reset mid-transaction**: the strobes drop in the same cycle reset asserts, and no response is delivered.

## Test plan
- **Single I fetch**: `i_read=1`, `i_address=32'hBFC00000`, memory `waitrequest=0`, `readdata=32'h24020005`.
  - Cycle 1: `read=1`, `address=32'hBFC00000`, `byteenable=4'hF`.
  - Cycle 2: `i_waitrequest=0`, `i_readdata=32'h24020005`.
- **Contention**: `i_read` and `d_read` both asserted at the first cycle after reset.
  - I is served first, then D.
  - Repeat with both still asserted: order alternates I, D, I, D.
- **Data write with stall**: `d_write=1`, `d_address=32'h10`, `d_writedata=32'hDEADBEEF`, `d_byteenable=4'b0011`, `waitrequest` held 1 for 5 cycles.
  - Bus fields are stable for 6 cycles.
  - `d_waitrequest=0` in exactly one cycle, 7 cycles after the request.
  - `d_readdata` is unchanged.
- **Read+write on D**: `d_read=1` and `d_write=1` together give `write=1`, `read=0` on the bus.
- **Timeout**: `TIMEOUT_CYCLES=8`, `waitrequest` held high 20 cycles.
  - `bus_timeout` rises on the 8th stall cycle and stays 1 after completion.
  - It clears only on `reset`.
- **Async reset mid-transaction**: assert `reset` between clock edges while in BUS_D.
  - `write`/`read` go to 0 and `d_waitrequest` goes to 1 before the next edge.
  - After release, a new `i_read` is served normally.
